alu_exec_unit: RTL and testbench

//  Parametrised RV32I/RV64I integer execute unit: decodes opcode/funct3/funct7 into a 4-bit ALU op, executes on

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_op_decode.sv | 61 ++++++
 rtl/alu_exec_unit.sv | 162 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the integer execute unit: ALU op codes, RV opcodes and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  function automatic logic isShiftOp(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I/RV64I decode of opcode/funct3/funct7 into an ALU op plus an illegal flag.
module alu_op_decode import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_t    alu_op_o,
  output logic       illegal_o
);

  // On RV64 funct7[0] of a shift immediate is shamt[5], so it is excluded from the checks.
  localparam logic [6:0] SHAMT_HI = (XLEN == 64) ? 7'b0000001 : 7'b0000000;

  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_LOAD, OPC_STORE, OPC_AUIPC: alu_op_o = ALU_ADD;
      OPC_LUI:                        alu_op_o = ALU_PASS_B;
      OPC_OP: begin
        if ((funct7_i != 7'b0000000) && (funct7_i != 7'b0100000)) begin
          illegal_o = 1'b1;
        end else if (funct7_i[5] && (funct3_i != 3'b000) && (funct3_i != 3'b101)) begin
          illegal_o = 1'b1;
        end else begin
          case (funct3_i)
            3'b000:  alu_op_o = funct7_i[5] ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op_o = ALU_SLL;
            3'b010:  alu_op_o = ALU_SLT;
            3'b011:  alu_op_o = ALU_SLTU;
            3'b100:  alu_op_o = ALU_XOR;
            3'b101:  alu_op_o = funct7_i[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op_o = ALU_OR;
            default: alu_op_o = ALU_AND;
          endcase
        end
      end
      OPC_OPIMM: begin
        case (funct3_i)
          3'b000:  alu_op_o = ALU_ADD;
          3'b001: begin
            alu_op_o  = ALU_SLL;
            illegal_o = ((funct7_i & ~SHAMT_HI) != 7'b0000000);
          end
          3'b010:  alu_op_o = ALU_SLT;
          3'b011:  alu_op_o = ALU_SLTU;
          3'b100:  alu_op_o = ALU_XOR;
          3'b101: begin
            alu_op_o  = funct7_i[5] ? ALU_SRA : ALU_SRL;
            illegal_o = ((funct7_i & ~(7'b0100000 | SHAMT_HI)) != 7'b0000000);
          end
          3'b110:  alu_op_o = ALU_OR;
          default: alu_op_o = ALU_AND;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute unit with valid/ready handshakes and a registered result.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts iterate SHIFT_STEP bits per cycle.
module alu_exec_unit import alu_pkg::*; #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  state_t          state_q, state_d;
  alu_op_t         op_q, op_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  alu_op_t         decOp;
  logic            decIllegal;
  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            goBusy;
  logic [XLEN-1:0] computed;
  logic [CW-1:0]   stepAmt;
  logic [XLEN-1:0] shifted;

  alu_op_decode #(.XLEN(XLEN)) u_decode (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .alu_op_o  (decOp),
    .illegal_o (decIllegal)
  );

  // Single-cycle result; in the iterative build a shift only lands here when shamt is zero.
  function automatic logic [XLEN-1:0] aluCompute(input alu_op_t op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
`ifdef ALU_BARREL_SHIFT_EN
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
`endif
    case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_SLT:    r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   r = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:    r = a ^ b;
      ALU_OR:     r = a | b;
      ALU_AND:    r = a & b;
      ALU_PASS_B: r = b;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:    r = a << sh;
      ALU_SRL:    r = a >> sh;
      ALU_SRA:    r = $signed(a) >>> sh;
`else
      ALU_SLL, ALU_SRL, ALU_SRA: r = a;
`endif
      default:    r = '0;
    endcase
    return r;
  endfunction

  assign shamt    = op_b[SHW-1:0];
  assign in_ready = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign computed = decIllegal ? '0 : aluCompute(decOp, op_a, op_b);

`ifdef ALU_BARREL_SHIFT_EN
  assign goBusy = 1'b0;
`else
  assign goBusy = isShiftOp(decOp) && !decIllegal && (shamt != '0);
`endif

  // Last step may be shorter than SHIFT_STEP so the total never overshoots shamt.
  always_comb begin
    stepAmt = (rem_q > STEP) ? STEP : rem_q;
    case (op_q)
      ALU_SLL: shifted = work_q << stepAmt;
      ALU_SRA: shifted = $signed(work_q) >>> stepAmt;
      default: shifted = work_q >> stepAmt;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    rem_d     = rem_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (state_q == ST_BUSY) begin
      work_d = shifted;
      rem_d  = rem_q - stepAmt;
      if (rem_q == stepAmt) begin
        state_d   = ST_DONE;
        result_d  = shifted;
        zero_d    = (shifted == '0);
        illegal_d = 1'b0;
      end
    end else if (accept) begin
      if (goBusy) begin
        state_d = ST_BUSY;
        op_d    = decOp;
        work_d  = op_a;
        rem_d   = {1'b0, shamt};
      end else begin
        state_d   = ST_DONE;
        result_d  = computed;
        zero_d    = (computed == '0);
        illegal_d = decIllegal;
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= ALU_ADD;
      work_q    <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      work_q    <= work_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: one instance with SHIFT_STEP=1 and one with SHIFT_STEP=4 share operand inputs.
module tb_alu_exec_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  inValid, inReady, outValid, outReady, zeroO, illegalO;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] opA, opB, resStep1, resStep4;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    int          dutIdx;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic        expIll;
    int          expLat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dutStep1 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .op_a(opA), .op_b(opB),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .result(resStep1),
    .zero(zeroO[0]), .illegal(illegalO[0])
  );

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dutStep4 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .op_a(opA), .op_b(opB),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .result(resStep4),
    .zero(zeroO[1]), .illegal(illegalO[1])
  );

  // Accept-to-valid latency: one cycle, plus one per SHIFT_STEP chunk of a nonzero shift.
  function automatic int latOf(input int step, input int sh, input logic isSh);
    int l;
    l = (isSh && sh != 0) ? 1 + (sh + step - 1) / step : 1;
`ifdef ALU_BARREL_SHIFT_EN
    l = 1;
`endif
    return l;
  endfunction

  // Reference model straight from the ISA rules, 32-bit only.
  function automatic void refModel(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic ill, output logic isSh);
    int sh;
    logic [31:0] ones;
    sh   = int'(b[4:0]);
    ones = 32'hFFFF_FFFF;
    res  = 32'h0;
    ill  = 1'b0;
    isSh = 1'b0;
    if (opc == OP_LOAD || opc == OP_STORE || opc == OP_AUIPC) begin
      res = a + b;
    end else if (opc == OP_LUI) begin
      res = b;
    end else if (opc == OP_REG || opc == OP_IMM) begin
      if (opc == OP_REG)
        ill = (f7 != 7'h00 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
      else
        ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && (f7 & 7'h5F) != 7'h00);
      if (!ill) begin
        case (f3)
          3'd0: res = (opc == OP_REG && f7 == 7'h20) ? a - b : a + b;
          3'd1: begin res = a << sh; isSh = 1'b1; end
          3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: res = (a < b) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd5: begin
            isSh = 1'b1;
            res  = a >> sh;
            if (f7[5] && a[31]) res = res | ~(ones >> sh);
          end
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end
    end else begin
      ill = 1'b1;
    end
    if (ill) res = 32'h0;
  endfunction

  function automatic vec_t mk(input int idx, input logic [6:0] opc, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] expRes, input logic expIll, input int expLat,
                              input string name);
    vec_t v;
    v.dutIdx = idx; v.opc = opc; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
    v.expRes = expRes; v.expIll = expIll; v.expLat = expLat; v.name = name;
    return v;
  endfunction

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one request to the chosen instance and wait (bounded) for its result.
  task automatic applyStimulus(input int idx, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output logic [31:0] res, output logic z,
                               output logic ill, output logic ok);
    int waited;
    @(negedge clk);
    opcode = opc; funct3 = f3; funct7 = f7; opA = a; opB = b;
    inValid[idx]  = 1'b1;
    outReady[idx] = 1'b1;
    waited = 0;
    while (!inReady[idx] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    lat = 0; res = 32'h0; z = 1'b0; ill = 1'b0; ok = 1'b0;
    if (!inReady[idx]) begin
      inValid[idx] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    inValid[idx] = 1'b0;
    lat = 1;
    while (!outValid[idx] && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    res = (idx == 0) ? resStep1 : resStep4;
    z   = zeroO[idx];
    ill = illegalO[idx];
    ok  = outValid[idx];
  endtask

  task automatic runVector(input vec_t v);
    int lat;
    logic [31:0] res;
    logic z, ill, ok;
    applyStimulus(v.dutIdx, v.opc, v.f3, v.f7, v.a, v.b, lat, res, z, ill, ok);
    checkOutput({v.name, " completed"}, {31'h0, ok}, 32'h1);
    if (ok) begin
      checkOutput({v.name, " result"}, res, v.expRes);
      checkOutput({v.name, " zero"}, {31'h0, z}, {31'h0, (v.expRes == 32'h0)});
      checkOutput({v.name, " illegal"}, {31'h0, ill}, {31'h0, v.expIll});
      checkOutput({v.name, " latency"}, 32'(lat), 32'(v.expLat));
    end
  endtask

  task automatic drain();
    @(negedge clk);
    inValid  = 2'b00;
    outReady = 2'b11;
    @(negedge clk);
  endtask

  initial begin
    int lat, sawValid, waited;
    logic [31:0] expRes, res;
    logic expIll, isSh, z, ill, ok;
    logic [6:0] opc, f7;
    logic [6:0] opcTab [6];

    opcTab[0] = OP_LOAD; opcTab[1] = OP_STORE; opcTab[2] = OP_IMM;
    opcTab[3] = OP_REG;  opcTab[4] = OP_LUI;   opcTab[5] = OP_AUIPC;

    vecs.push_back(mk(0, OP_REG, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1, "add overflow"));
    vecs.push_back(mk(0, OP_REG, 3'd0, 7'h20, 32'h1234, 32'h1234, 32'h0, 1'b0, 1, "sub to zero"));
    vecs.push_back(mk(0, OP_REG, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1, "slt signed"));
    vecs.push_back(mk(0, OP_REG, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, "sltu unsigned"));
    vecs.push_back(mk(0, OP_REG, 3'd5, 7'h20, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, latOf(1, 31, 1'b1), "sra 31 step1"));
    vecs.push_back(mk(1, OP_IMM, 3'd1, 7'h00, 32'h1, 32'd0, 32'h1, 1'b0, 1, "sll shamt0 step4"));
    vecs.push_back(mk(1, OP_IMM, 3'd1, 7'h00, 32'h1, 32'd5, 32'h20, 1'b0, latOf(4, 5, 1'b1), "sll shamt5 step4"));
    vecs.push_back(mk(0, OP_REG, 3'd4, 7'h20, 32'h55, 32'h66, 32'h0, 1'b1, 1, "illegal xor funct7"));
    vecs.push_back(mk(0, OP_LUI, 3'd0, 7'h00, 32'h1111, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1, "lui pass b"));
    vecs.push_back(mk(0, OP_AUIPC, 3'd0, 7'h00, 32'h1000, 32'h234, 32'h1234, 1'b0, 1, "auipc add"));
    vecs.push_back(mk(1, 7'b1111111, 3'd0, 7'h00, 32'h1, 32'h2, 32'h0, 1'b1, 1, "illegal opcode"));
    vecs.push_back(mk(1, OP_IMM, 3'd5, 7'h00, 32'hF000_0000, 32'd28, 32'hF, 1'b0, latOf(4, 28, 1'b1), "srli 28 step4"));
    vecs.push_back(mk(1, OP_IMM, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, latOf(4, 4, 1'b1), "srai 4 step4"));
    vecs.push_back(mk(0, OP_IMM, 3'd1, 7'h20, 32'h1, 32'd3, 32'h0, 1'b1, 1, "illegal slli funct7"));

    rst = 1'b1; inValid = 2'b00; outReady = 2'b00;
    opcode = 7'h0; funct3 = 3'h0; funct7 = 7'h0; opA = 32'h0; opB = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset out_valid dut%0d", d), {31'h0, outValid[d]}, 32'h0);
      checkOutput($sformatf("reset in_ready dut%0d", d), {31'h0, inReady[d]}, 32'h0);
      checkOutput($sformatf("reset zero dut%0d", d), {31'h0, zeroO[d]}, 32'h0);
      checkOutput($sformatf("reset illegal dut%0d", d), {31'h0, illegalO[d]}, 32'h0);
    end
    checkOutput("reset result dut0", resStep1, 32'h0);
    checkOutput("reset result dut1", resStep4, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) runVector(vecs[i]);

    // Backpressure: first result must hold while a second request waits.
    drain();
    opcode = OP_REG; funct3 = 3'd0; funct7 = 7'h00; opA = 32'd5; opB = 32'd6;
    inValid[0] = 1'b1; outReady[0] = 1'b0;
    @(posedge clk); #1;
    funct7 = 7'h20; opA = 32'd9; opB = 32'd4;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("backpressure valid c%0d", c), {31'h0, outValid[0]}, 32'h1);
      checkOutput($sformatf("backpressure result c%0d", c), resStep1, 32'd11);
      checkOutput($sformatf("backpressure in_ready c%0d", c), {31'h0, inReady[0]}, 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    outReady[0] = 1'b1;
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    waited = 0;
    while (!outValid[0] && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("held request valid", {31'h0, outValid[0]}, 32'h1);
    checkOutput("held request result", resStep1, 32'd5);

    // Reset in the middle of an iterative shift must drop it silently.
    drain();
    opcode = OP_REG; funct3 = 3'd1; funct7 = 7'h00; opA = 32'h1; opB = 32'd20;
    inValid[0] = 1'b1;
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sawValid = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (outValid[0]) sawValid++;
    end
    checkOutput("reset mid-busy no output", 32'(sawValid), 32'h0);
    runVector(mk(0, OP_REG, 3'd4, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1, "after reset xor"));

    for (int i = 0; i < 150; i++) begin
      automatic int idx = $urandom_range(0, 1);
      automatic int pick = $urandom_range(0, 6);
      automatic int f7pick = $urandom_range(0, 2);
      automatic logic [2:0] f3 = 3'($urandom);
      automatic logic [31:0] a = $urandom;
      automatic logic [31:0] b = $urandom;
      opc = (pick < 6) ? opcTab[pick] : 7'($urandom);
      f7  = (f7pick == 0) ? 7'h00 : (f7pick == 1) ? 7'h20 : 7'($urandom);
      refModel(opc, f3, f7, a, b, expRes, expIll, isSh);
      runVector(mk(idx, opc, f3, f7, a, b, expRes, expIll,
                   latOf((idx == 0) ? 1 : 4, int'(b[4:0]), isSh), $sformatf("rand%0d", i)));
    end

    // Confirm a plain back-to-back issue after the random run still resolves.
    applyStimulus(1, OP_IMM, 3'd6, 7'h00, 32'h0F00, 32'h00F0, lat, res, z, ill, ok);
    checkOutput("final ori result", res, 32'h0FF0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
